// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared index types and width helpers for the ping-pong ring store
package pp_pkg;

  localparam int unsigned DEF_BANK_NUM = 8;
  localparam int unsigned DEF_BUF_NUM  = 3;

  // Width of an index into n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef logic [idx_w(DEF_BANK_NUM)-1:0] lane_idx_t;
  typedef logic [idx_w(DEF_BUF_NUM)-1:0]  buf_idx_t;

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - one buffer: lane-enabled word write, whole-word read with fixed latency
module ram_bank #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LANE_WIDTH = 64,
  parameter int unsigned LANE_NUM   = 8,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [LANE_NUM-1:0]            wbe,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] wdata,
  input  logic                           re,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [LANE_NUM*LANE_WIDTH-1:0] rdata
);

  localparam int unsigned DW = LANE_NUM * LANE_WIDTH;

  logic [DW-1:0] mem [2**ADDR_WIDTH];
  logic [DW-1:0] pipe_d [LATENCY];
  logic [DW-1:0] pipe_q [LATENCY];

  always_comb begin
    pipe_d = pipe_q;
    if (re) pipe_d[0] = mem[raddr];
    for (int s = 1; s < LATENCY; s++) pipe_d[s] = pipe_q[s-1];
  end

  // Storage and data pipeline are deliberately unreset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANE_NUM; l++) begin
        if (wbe[l]) mem[waddr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    pipe_q <= pipe_d;
  end

  assign rdata = pipe_q[LATENCY-1];

endmodule

// File: rtl/pp_ring_st.sv
// rtl/pp_ring_st.sv - BUF_NUM-deep buffer ring: writer fills whole words, reader fetches lanes
module pp_ring_st
  import pp_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 512,
  parameter int unsigned IN_ADDR_WIDTH  = 10,
  parameter int unsigned OUT_DATA_WIDTH = 64,
  parameter int unsigned BANK_NUM       = 8,
  parameter int unsigned BUF_NUM        = 3,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned CPLX           = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wen,
  input  logic [IN_ADDR_WIDTH-1:0]                  waddr,
  input  logic [IN_DATA_WIDTH-1:0]                  wdata,
  input  logic                                      wr_done,
  output logic                                      wr_ready,
  input  logic                                      ren,
  input  logic [IN_ADDR_WIDTH+idx_w(BANK_NUM)-1:0]  raddr,
  input  logic                                      rd_done,
  output logic                                      rd_valid,
  output logic [OUT_DATA_WIDTH-1:0]                 rd_re,
  output logic [OUT_DATA_WIDTH-1:0]                 rd_im,
  output logic                                      rd_dvalid,
  output logic [cnt_w(BUF_NUM)-1:0]                 count,
  output logic [idx_w(BUF_NUM)-1:0]                 wr_idx,
  output logic [idx_w(BUF_NUM)-1:0]                 rd_idx,
  output logic                                      err
);

  localparam int unsigned LW = idx_w(BANK_NUM);
  localparam int unsigned BW = idx_w(BUF_NUM);
  localparam int unsigned CW = cnt_w(BUF_NUM);

  logic [BW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LW-1:0]      lane_q [LATENCY];
  logic [LW-1:0]      lane_d [LATENCY];
  logic [BW-1:0]      bidx_q [LATENCY];
  logic [BW-1:0]      bidx_d [LATENCY];

  logic wr_ok, rd_ok, wr_acc, rd_acc, ren_ok;
  logic [IN_DATA_WIDTH-1:0] bank_rdata [BUF_NUM];
  logic [IN_DATA_WIDTH-1:0] sel_word;
  logic [LW-1:0]            lane_out, lane_im;

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == BW'(BUF_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ok  = (cnt_q < CW'(BUF_NUM));
  assign rd_ok  = (cnt_q != '0);
  assign wr_acc = wr_done && wr_ok;
  assign rd_acc = rd_done && rd_ok;
  assign ren_ok = ren && rd_ok;

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    vld_d  = '0;
    lane_d = lane_q;
    bidx_d = bidx_q;
    if (wr_acc) wp_d = ptr_inc(wp_q);
    if (rd_acc) rp_d = ptr_inc(rp_q);
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + 1'b1;
    else if (rd_acc && !wr_acc) cnt_d = cnt_q - 1'b1;
    if (((wen || wr_done) && !wr_ok) || ((ren || rd_done) && !rd_ok)) err_d = 1'b1;
    // Stage 0 captures the pre-advance rp, so a read in the rd_done cycle sees the old buffer.
    vld_d[0]  = ren_ok;
    lane_d[0] = raddr[IN_ADDR_WIDTH +: LW];
    bidx_d[0] = rp_q;
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s]  = vld_q[s-1];
      lane_d[s] = lane_q[s-1];
      bidx_d[s] = bidx_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        lane_q[s] <= '0;
        bidx_q[s] <= '0;
      end
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
      lane_q <= lane_d;
      bidx_q <= bidx_d;
    end
  end

  // A full ring is the only state with wp == rp and count > 0, and wr_ok blocks it.
  for (genvar b = 0; b < BUF_NUM; b++) begin : g_bank
    ram_bank #(
      .ADDR_WIDTH (IN_ADDR_WIDTH),
      .LANE_WIDTH (OUT_DATA_WIDTH),
      .LANE_NUM   (BANK_NUM),
      .LATENCY    (LATENCY)
    ) u_bank (
      .clk   (clk),
      .we    (wen && wr_ok && (wp_q == BW'(b))),
      .wbe   ({BANK_NUM{1'b1}}),
      .waddr (waddr),
      .wdata (wdata),
      .re    (ren_ok && (rp_q == BW'(b))),
      .raddr (raddr[IN_ADDR_WIDTH-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  assign lane_out = lane_q[LATENCY-1];
  assign lane_im  = lane_out + 1'b1;

  always_comb begin
    sel_word = '0;
    rd_re    = '0;
    rd_im    = '0;
    for (int b = 0; b < BUF_NUM; b++) begin
      if (bidx_q[LATENCY-1] == BW'(b)) sel_word = bank_rdata[b];
    end
    if (vld_q[LATENCY-1]) begin
      rd_re = sel_word[lane_out*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      if (CPLX != 0) rd_im = sel_word[lane_im*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    end
  end

  assign wr_ready  = wr_ok;
  assign rd_valid  = rd_ok;
  assign rd_dvalid = vld_q[LATENCY-1];
  assign count     = cnt_q;
  assign wr_idx    = wp_q;
  assign rd_idx    = rp_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pp_ring_st.sv
// tb/tb_pp_ring_st.sv - bench for pp_ring_st: three configurations share one stimulus stream
module tb_pp_ring_st;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wen = 1'b0, wr_done = 1'b0, ren = 1'b0, rd_done = 1'b0;
  logic [9:0]   waddr = '0;
  logic [511:0] wdata = '0;
  logic [12:0]  raddr = '0;

  logic        wr_ready_a, rd_valid_a, rd_dvalid_a, err_a;
  logic        wr_ready_b, rd_valid_b, rd_dvalid_b, err_b;
  logic        wr_ready_c, rd_valid_c, rd_dvalid_c, err_c;
  logic [63:0] rd_re_a, rd_im_a, rd_re_b, rd_im_b, rd_re_c, rd_im_c;
  logic [1:0]  count_a, wr_idx_a, rd_idx_a;
  logic [1:0]  count_b, wr_idx_b, rd_idx_b;
  logic [1:0]  count_c, wr_idx_c, rd_idx_c;

  pp_ring_st dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wr_done(wr_done),
    .wr_ready(wr_ready_a), .ren(ren), .raddr(raddr), .rd_done(rd_done), .rd_valid(rd_valid_a),
    .rd_re(rd_re_a), .rd_im(rd_im_a), .rd_dvalid(rd_dvalid_a), .count(count_a),
    .wr_idx(wr_idx_a), .rd_idx(rd_idx_a), .err(err_a)
  );

  pp_ring_st #(.CPLX(0)) dut_c0 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wr_done(wr_done),
    .wr_ready(wr_ready_b), .ren(ren), .raddr(raddr), .rd_done(rd_done), .rd_valid(rd_valid_b),
    .rd_re(rd_re_b), .rd_im(rd_im_b), .rd_dvalid(rd_dvalid_b), .count(count_b),
    .wr_idx(wr_idx_b), .rd_idx(rd_idx_b), .err(err_b)
  );

  pp_ring_st #(.LATENCY(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wr_done(wr_done),
    .wr_ready(wr_ready_c), .ren(ren), .raddr(raddr), .rd_done(rd_done), .rd_valid(rd_valid_c),
    .rd_re(rd_re_c), .rd_im(rd_im_c), .rd_dvalid(rd_dvalid_c), .count(count_c),
    .wr_idx(wr_idx_c), .rd_idx(rd_idx_c), .err(err_c)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: ring state as plain integers, buffer contents as whole words.
  int           wp_m = 0, rp_m = 0, cnt_m = 0;
  bit           err_m = 1'b0;
  logic [511:0] mem_m [3][8];
  bit           wtn [3][8];
  bit           hv [16];
  bit           hk [16];
  logic [63:0]  hre [16];
  logic [63:0]  him [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    wp_m = 0; rp_m = 0; cnt_m = 0; err_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hv[i] = 1'b0; hk[i] = 1'b0; hre[i] = '0; him[i] = '0;
    end
  endfunction

  function automatic logic [511:0] rnd_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk_data(input string tag, input logic dv, input logic [63:0] re,
                          input logic [63:0] im, input int slot, input bit cplx);
    chk({tag, "_dvalid"}, 64'(dv), 64'(hv[slot]));
    if (hv[slot] && hk[slot]) begin
      chk({tag, "_re"}, re, hre[slot]);
      chk({tag, "_im"}, im, cplx ? him[slot] : 64'h0);
    end else if (!hv[slot]) begin
      chk({tag, "_re_idle"}, re, 64'h0);
      chk({tag, "_im_idle"}, im, 64'h0);
    end else if (!cplx) begin
      chk({tag, "_im_zero"}, im, 64'h0);
    end
  endtask

  task automatic check_all();
    int s1, s3;
    s1 = cyc & 15;
    s3 = (cyc - 2) & 15;
    chk("wr_ready", 64'(wr_ready_a), 64'(cnt_m < 3));
    chk("rd_valid", 64'(rd_valid_a), 64'(cnt_m > 0));
    chk("count", 64'(count_a), 64'(cnt_m));
    chk("wr_idx", 64'(wr_idx_a), 64'(wp_m));
    chk("rd_idx", 64'(rd_idx_a), 64'(rp_m));
    chk("err", 64'(err_a), 64'(err_m));
    chk("count_l3", 64'(count_c), 64'(cnt_m));
    chk_data("a", rd_dvalid_a, rd_re_a, rd_im_a, s1, 1'b1);
    chk_data("c0", rd_dvalid_b, rd_re_b, rd_im_b, s1, 1'b0);
    chk_data("l3", rd_dvalid_c, rd_re_c, rd_im_c, s3, 1'b1);
  endtask

  task automatic tick();
    int slot, word, lane;
    bit wr_ok, rd_ok;
    slot = cyc & 15;
    hv[slot] = 1'b0; hk[slot] = 1'b0; hre[slot] = '0; him[slot] = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      wr_ok = (cnt_m < 3);
      rd_ok = (cnt_m > 0);
      if (((wen || wr_done) && !wr_ok) || ((ren || rd_done) && !rd_ok)) err_m = 1'b1;
      if (ren && rd_ok) begin
        word = int'(raddr[9:0]);
        lane = int'(raddr[12:10]);
        hv[slot] = 1'b1;
        if (word < 8 && wtn[rp_m][word]) begin
          hk[slot]  = 1'b1;
          hre[slot] = mem_m[rp_m][word][lane*64 +: 64];
          him[slot] = mem_m[rp_m][word][((lane + 1) % 8)*64 +: 64];
        end
      end
      if (wen && wr_ok && waddr < 8) begin
        mem_m[wp_m][waddr] = wdata;
        wtn[wp_m][waddr]   = 1'b1;
      end
      if (wr_done && wr_ok) begin wp_m = (wp_m + 1) % 3; cnt_m++; end
      if (rd_done && rd_ok) begin rp_m = (rp_m + 1) % 3; cnt_m--; end
    end
    @(posedge clk);
    #1;
    check_all();
    cyc++;
  endtask

  task automatic idle();
    wen = 1'b0; wr_done = 1'b0; ren = 1'b0; rd_done = 1'b0;
  endtask

  initial begin
    logic [511:0] w;
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_wr_ready", 64'(wr_ready_a), 64'h1);
    chk("rst_rd_valid", 64'(rd_valid_a), 64'h0);
    chk("rst_count", 64'(count_a), 64'h0);
    chk("rst_err", 64'(err_a), 64'h0);
    chk("rst_dvalid", 64'(rd_dvalid_a), 64'h0);
    rst_n = 1'b1;

    // Fill-drain: word 5 lanes k*0x11, word 6 lanes 0x100+k
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'(k * 'h11);
    wen = 1'b1; waddr = 10'd5; wdata = w;
    tick();
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = 64'('h100 + k);
    waddr = 10'd6; wdata = w;
    tick();
    idle(); wr_done = 1'b1;
    tick();
    chk("fd_count", 64'(count_a), 64'h1);
    chk("fd_rd_valid", 64'(rd_valid_a), 64'h1);
    idle(); ren = 1'b1; raddr = {3'd2, 10'd5};
    tick();
    chk("fd_dvalid", 64'(rd_dvalid_a), 64'h1);
    chk("fd_re", rd_re_a, 64'h22);
    chk("fd_im", rd_im_a, 64'h33);
    raddr = {3'd7, 10'd6};
    tick();
    chk("wrap_re", rd_re_a, 64'h107);
    chk("wrap_im", rd_im_a, 64'h100);
    chk("wrap_im_c0", rd_im_b, 64'h0);
    idle();
    tick();

    // Simultaneous commit and release with one filled buffer
    wr_done = 1'b1; rd_done = 1'b1;
    tick();
    chk("sim_count", 64'(count_a), 64'h1);
    chk("sim_wp", 64'(wr_idx_a), 64'h2);
    chk("sim_rp", 64'(rd_idx_a), 64'h1);

    // Full ring and overflow
    idle(); wr_done = 1'b1;
    tick();
    tick();
    chk("full_count", 64'(count_a), 64'h3);
    chk("full_wr_ready", 64'(wr_ready_a), 64'h0);
    chk("full_err_clear", 64'(err_a), 64'h0);
    tick();
    chk("ovf_err", 64'(err_a), 64'h1);
    chk("ovf_count", 64'(count_a), 64'h3);
    idle();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    chk("err_cleared", 64'(err_a), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wen     = ($urandom_range(0, 1) == 0);
      waddr   = 10'($urandom_range(0, 7));
      wdata   = rnd_word();
      wr_done = ($urandom_range(0, 3) == 0);
      ren     = ($urandom_range(0, 1) == 0);
      raddr   = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 7))};
      rd_done = ($urandom_range(0, 3) == 0);
      tick();
      if (i == 200) begin
        idle();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
    end
    idle();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;

    // Reset while a LATENCY=3 read is in flight
    wen = 1'b1; waddr = 10'd2; wdata = rnd_word(); wr_done = 1'b1;
    tick();
    idle(); ren = 1'b1; raddr = {3'd3, 10'd2};
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_count", 64'(count_c), 64'h0);
    chk("mid_wp", 64'(wr_idx_c), 64'h0);
    chk("mid_rp", 64'(rd_idx_c), 64'h0);
    chk("mid_err", 64'(err_c), 64'h0);
    chk("mid_dvalid", 64'(rd_dvalid_c), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_dvalid", 64'(rd_dvalid_c), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pp_ring_st.md
PP_RING_ST -- requirements
Module: pp_ring_st

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 512, write word width (BANK_NUM lanes).
REQ-002 SHALL have parameter IN_ADDR_WIDTH, default 10, word address width per buffer.
REQ-003 SHALL have parameter OUT_DATA_WIDTH, default 64, lane width; IN_DATA_WIDTH = BANK_NUM*OUT_DATA_WIDTH.
REQ-004 SHALL have parameter BANK_NUM, default 8, lanes per word, power of 2.
REQ-005 SHALL have parameter BUF_NUM, default 3, buffer count, >= 2.
REQ-006 SHALL have parameter LATENCY, default 1, RAM read latency, >= 1.
REQ-007 SHALL have parameter CPLX, default 1; 1 = re/im lane pair read, 0 = single lane read with rd_im = 0.
REQ-008 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: wen in 1, word write strobe; waddr in IN_ADDR_WIDTH; wdata in IN_DATA_WIDTH; wr_done in 1, commit current write buffer.
REQ-010 SHALL have output wr_ready, 1 bit, a free buffer is owned by the writer.
REQ-011 SHALL have ports: ren in 1; raddr in IN_ADDR_WIDTH+log2(BANK_NUM), MSBs = lane, LSBs = word; rd_done in 1, release current read buffer.
REQ-012 SHALL have outputs: rd_valid 1, filled buffer available; rd_re, rd_im OUT_DATA_WIDTH; rd_dvalid 1, marks read data.
REQ-013 SHALL have outputs: count log2(BUF_NUM+1), filled buffers; wr_idx, rd_idx log2(BUF_NUM); err 1, sticky protocol error.

Function
REQ-014 SHALL keep write pointer wp, read pointer rp (mod BUF_NUM) and count 0..BUF_NUM.
REQ-015 SHALL drive wr_ready = (count < BUF_NUM), rd_valid = (count > 0), wr_idx = wp, rd_idx = rp.
REQ-016 SHALL write wdata to buffer wp at waddr, all lanes, when wen && wr_ready.
REQ-017 SHALL on wr_done && wr_ready advance wp by 1 mod BUF_NUM and increment count, effective next cycle.
REQ-018 SHALL on rd_done && rd_valid advance rp by 1 mod BUF_NUM and decrement count.
REQ-019 SHALL on a same-cycle accepted wr_done and rd_done advance both pointers and leave count unchanged.
REQ-020 SHALL read buffer rp at raddr word bits when ren && rd_valid; a read in the rd_done cycle uses the old rp.
REQ-021 SHALL return read data exactly LATENCY cycles after ren, with rd_dvalid high that cycle; lane and buffer index are pipelined alongside.
REQ-022 SHALL set rd_re = lane L; with CPLX=1 set rd_im = lane (L+1) mod BANK_NUM; L = BANK_NUM-1 wraps to lane 0.
REQ-023 SHALL hold rd_re/rd_im at 0 when rd_dvalid is low.
REQ-024 SHALL ignore wen/wr_done when !wr_ready and ren/rd_done when !rd_valid, setting err, which holds until reset.
REQ-025 SHALL never write to buffer rp while count > 0 and wp != rp, so reads and writes never collide.

Reset
REQ-026 SHALL on rst_n low asynchronously clear wp, rp, count, err, the rd_dvalid and index pipelines, and rd_re/rd_im.
REQ-027 SHALL leave RAM contents unreset; after reset all buffers are free: wr_ready=1, rd_valid=0.
REQ-028 SHALL drop in-flight reads on reset mid-operation; no rd_dvalid follows the deassertion of rst_n.

Structure
REQ-029 SHALL place the lane index and buffer index typedefs and the log2 width helpers in shared package pp_pkg.
REQ-030 SHALL instantiate existing sub-module ram_bank BUF_NUM times (generate), all lanes enabled together.
REQ-031 SHALL contain pointer/count control, read-side mux and latency pipeline in this module only.

Verification
REQ-032 Fill-drain: BUF_NUM=3; write buffer 0 word 5 = lanes k*0x11, wr_done -> count=1, rd_valid=1; ren raddr lane 2 word 5 -> after LATENCY rd_re=0x22, rd_im=0x33, rd_dvalid=1.
REQ-033 Full: three wr_done without rd_done -> count=3, wr_ready=0; fourth wr_done -> ignored, err=1, count stays 3.
REQ-034 Simultaneous: count=1, wr_done and rd_done in same cycle -> count=1, wp and rp both +1.
REQ-035 Lane wrap: raddr lane 7 (BANK_NUM=8, CPLX=1) -> rd_im = lane 0 data; CPLX=0 -> rd_im=0.
REQ-036 Reset mid-op: LATENCY=3, ren then rst_n low 1 cycle later -> no rd_dvalid; count=0, wp=rp=0, err=0.
